// File: rtl/multiplier_controller.sv
// multiplier_controller: sequences load, WIDTH add/shift iterations and completion for a shift-add multiplier
module multiplier_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             LSB,
  output logic             W_ctrl,
  output logic             P_load,
  output logic             ADDU_ctrl,
  output logic             SRL_ctrl,
  output logic             Busy,
  output logic             Ready,
  output logic [CNT_W-1:0] Iter
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [4:0] C_LOAD = 5'b11010;
  localparam logic [4:0] C_CALC = 5'b00110;
  localparam logic [4:0] C_DONE = 5'b00001;
  state_t state;
  logic [4:0] ctl;
  assign {W_ctrl, P_load, SRL_ctrl, Busy, Ready} = ctl;
  // SRL_ctrl is high exactly in CALC, so it doubles as the state qualifier here
  assign ADDU_ctrl = SRL_ctrl & LSB;
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= IDLE;
      Iter  <= '0;
      ctl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= Run ? LOAD : IDLE;
          ctl   <= Run ? C_LOAD : '0;
        end
        LOAD: begin
          state <= CALC;
          Iter  <= '0;
          ctl   <= C_CALC;
        end
        CALC: begin
          Iter  <= Iter + 1'b1;
          state <= (Iter == LAST) ? DONE : CALC;
          ctl   <= (Iter == LAST) ? C_DONE : C_CALC;
        end
        DONE: begin
          state <= IDLE;
          ctl   <= '0;
        end
        default: begin
          state <= IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_controller.sv
// tb_multiplier_controller: directed checks of the controller driving a behavioural shift-add datapath
module tb_multiplier_controller;
  logic clk = 0;
  logic Reset;
  logic run32, run4;
  logic w32, pl32, addu32, srl32, busy32, rdy32;
  logic w4, pl4, addu4, srl4, busy4, rdy4;
  logic [5:0] it32;
  logic [2:0] it4;
  logic [31:0] mc32, mp32, m32 = '0;
  logic [63:0] p32 = '0;
  logic [32:0] s32;
  logic [3:0] mc4, mp4, m4 = '0;
  logic [7:0] p4 = '0;
  logic [4:0] s4;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multiplier_controller #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .Reset(Reset), .Run(run32), .LSB(p32[0]),
    .W_ctrl(w32), .P_load(pl32), .ADDU_ctrl(addu32), .SRL_ctrl(srl32),
    .Busy(busy32), .Ready(rdy32), .Iter(it32)
  );

  multiplier_controller #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .Reset(Reset), .Run(run4), .LSB(p4[0]),
    .W_ctrl(w4), .P_load(pl4), .ADDU_ctrl(addu4), .SRL_ctrl(srl4),
    .Busy(busy4), .Ready(rdy4), .Iter(it4)
  );

  // behavioural datapaths: add multiplicand into the upper half, then shift right with carry
  assign s32 = {1'b0, p32[63:32]} + (addu32 ? {1'b0, m32} : 33'd0);
  assign s4  = {1'b0, p4[7:4]} + (addu4 ? {1'b0, m4} : 5'd0);
  always @(posedge clk) begin
    if (w32) m32 <= mc32;
    if (pl32) p32 <= {32'd0, mp32};
    else if (srl32) p32 <= {s32, p32[31:1]};
    if (w4) m4 <= mc4;
    if (pl4) p4 <= {4'd0, mp4};
    else if (srl4) p4 <= {s4, p4[3:1]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_k, srl_n, addu_bad, n_load, overlap, n_ready;
    int loads[4];
    logic hit;
    logic [3:0] pat;
    Reset = 0; run32 = 1; run4 = 1;
    mc32 = 125; mp32 = 3; mc4 = 7; mp4 = 5;
    repeat (2) begin
      tick();
      chk("rst_out32", {w32, pl32, addu32, srl32, busy32, rdy32}, 0);
      chk("rst_iter32", it32, 0);
      chk("rst_out4", {w4, pl4, addu4, srl4, busy4, rdy4}, 0);
      chk("rst_iter4", it4, 0);
    end
    Reset = 1; run4 = 0;
    tick();
    run32 = 0;
    chk("load_wpb", {w32, pl32, srl32, busy32}, 4'b1101);
    ready_k = -1; srl_n = 0; addu_bad = 0;
    for (int i = 1; i <= 40 && ready_k < 0; i++) begin
      tick();
      if (srl32) begin
        if (addu32 !== (srl_n < 2)) addu_bad++;
        srl_n++;
      end
      if (rdy32) begin
        ready_k = i;
        chk("nom_busy_at_ready", busy32, 0);
      end
    end
    chk("nom_ready_k", ready_k, 33);
    chk("nom_srl_n", srl_n, 32);
    chk("nom_addu_bad", addu_bad, 0);
    chk("nom_iter", it32, 32);
    chk("nom_product", p32, 375);
    tick();
    chk("nom_idle_out", {w32, pl32, addu32, srl32, busy32, rdy32}, 0);
    chk("nom_iter_hold", it32, 32);
    run32 = 1;
    tick();
    run32 = 0;
    chk("ign_load", {w32, pl32}, 2'b11);
    ready_k = -1; srl_n = 0; hit = 0;
    for (int i = 1; i <= 40 && ready_k < 0; i++) begin
      tick();
      if (srl32) srl_n++;
      if (rdy32) ready_k = i;
      run32 = srl32 && it32 == 10;
      if (run32) hit = 1;
    end
    run32 = 0;
    chk("ign_pulsed", hit, 1);
    chk("ign_srl_n", srl_n, 32);
    chk("ign_ready_k", ready_k, 33);
    tick(); tick();
    chk("ign_idle_out", {w32, pl32, addu32, srl32, busy32, rdy32}, 0);
    run32 = 1; n_load = 0; overlap = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (w32 && n_load < 4) begin
        loads[n_load] = i;
        n_load++;
      end
      if (rdy32 && busy32) overlap++;
    end
    run32 = 0;
    chk("b2b_n_load", n_load, 3);
    chk("b2b_first", loads[0], 0);
    chk("b2b_period1", loads[1] - loads[0], 35);
    chk("b2b_period2", loads[2] - loads[1], 35);
    chk("b2b_overlap", overlap, 0);
    repeat (40) tick();
    chk("b2b_idle_out", {w32, pl32, addu32, srl32, busy32, rdy32}, 0);
    run32 = 1;
    tick();
    run32 = 0;
    hit = 0;
    for (int i = 1; i <= 40 && !hit; i++) begin
      tick();
      hit = srl32 && it32 == 17;
    end
    chk("abort_reached17", hit, 1);
    Reset = 0;
    tick();
    Reset = 1;
    chk("abort_out", {w32, pl32, addu32, srl32, busy32, rdy32}, 0);
    chk("abort_iter", it32, 0);
    n_ready = 0;
    repeat (40) begin
      tick();
      if (rdy32 || busy32) n_ready++;
    end
    chk("abort_no_ready", n_ready, 0);
    run4 = 1;
    tick();
    run4 = 0;
    chk("w4_load", {w4, pl4, busy4}, 3'b111);
    ready_k = -1; pat = '0;
    for (int i = 1; i <= 10 && ready_k < 0; i++) begin
      tick();
      if (srl4) pat = {pat[2:0], addu4};
      if (rdy4) ready_k = i;
    end
    chk("w4_ready_k", ready_k, 5);
    chk("w4_iter", it4, 4);
    chk("w4_addu_pat", pat, 4'b1010);
    chk("w4_product", p4, 35);
    tick();
    chk("w4_idle_out", {w4, pl4, addu4, srl4, busy4, rdy4}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
